suma_serial: RTL

Bit-serial M-bit two's-complement adder with a start/done handshake, the addition counterpart of the combinational subtractor in the lab ALU datapath. It processes one bit per clock, LSB first, through a single full-adder cell. At completion it publishes the sum and the same flag set as the subtractor: C, N, V, Z. It serves area-constrained datapaths where the ALU hands off an add and waits for `done`.

---
 rtl/suma_pkg.sv | 6 +
 rtl/suma_serial_full_adder.sv | 13 +
 rtl/suma_serial.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/suma_pkg.sv
// Shared types for the bit-serial adder: the controller state encoding.
package suma_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} suma_state_t;

endpackage

// File: rtl/suma_serial_full_adder.sv
// Single combinational full-adder cell; the only arithmetic in the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/suma_serial.sv
// Bit-serial M-bit two's-complement adder, LSB first, one bit per clock, with
// start/done handshake and C/N/V/Z flags published together with the sum.
module suma_serial
    import suma_pkg::*;
#(
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] A,
    input  logic [M-1:0] B,
    output logic [M-1:0] R,
    output logic         C,
    output logic         N,
    output logic         V,
    output logic         Z,
    output logic         busy,
    output logic         done
);

    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0] LAST = CW'(M - 1);

    suma_state_t state_q, state_d;

    logic [M-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
    logic          c_q, c_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          amsb_q, amsb_d, bmsb_q, bmsb_d;
    logic [M-1:0]  r_q, r_d;
    logic          cf_q, cf_d, n_q, n_d, v_q, v_d, z_q, z_d;
    logic          busy_q, busy_d, done_q, done_d;

    logic          fa_s, fa_c;
    logic [M-1:0]  sum_w;
    logic          load_w;

    full_adder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (c_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    // On the last RUN edge the incoming bit completes the sum.
    assign sum_w  = {fa_s, res_q[M-1:1]};
    assign load_w = start && ((state_q == IDLE) || (state_q == DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        res_d  = res_q;
        c_d    = c_q;
        cnt_d  = cnt_q;
        amsb_d = amsb_q;
        bmsb_d = bmsb_q;
        r_d    = r_q;
        cf_d   = cf_q;
        n_d    = n_q;
        v_d    = v_q;
        z_d    = z_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (load_w) begin
            a_d    = A;
            b_d    = B;
            res_d  = '0;
            c_d    = 1'b0;
            cnt_d  = '0;
            amsb_d = A[M-1];
            bmsb_d = B[M-1];
            busy_d = 1'b1;
        end else if (state_q == RUN) begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = sum_w;
            c_d   = fa_c;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                r_d    = sum_w;
                cf_d   = fa_c;
                n_d    = sum_w[M-1];
                z_d    = (sum_w == '0);
                v_d    = (amsb_q == bmsb_q) && (sum_w[M-1] != amsb_q);
                done_d = 1'b1;
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            c_q    <= 1'b0;
            cnt_q  <= '0;
            amsb_q <= 1'b0;
            bmsb_q <= 1'b0;
            r_q    <= '0;
            cf_q   <= 1'b0;
            n_q    <= 1'b0;
            v_q    <= 1'b0;
            z_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            res_q  <= res_d;
            c_q    <= c_d;
            cnt_q  <= cnt_d;
            amsb_q <= amsb_d;
            bmsb_q <= bmsb_d;
            r_q    <= r_d;
            cf_q   <= cf_d;
            n_q    <= n_d;
            v_q    <= v_d;
            z_q    <= z_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign R    = r_q;
    assign C    = cf_q;
    assign N    = n_q;
    assign V    = v_q;
    assign Z    = z_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
